// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host transmit path: FSM states, command
// bytes and timing defaults derived from the 14.318 MHz system clock.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_START,
        ST_BITS,
        ST_ACK,
        ST_ACK_REL,
        ST_FAIL
    } ps2_state_e;

    // Common host-to-device command bytes and the device acknowledge byte
    localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
    localparam logic [7:0] PS2_CMD_ENABLE  = 8'hF4;
    localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
    localparam logic [7:0] PS2_RSP_ACK     = 8'hFA;

    // Timing defaults in system clock cycles
    localparam int PS2_SYS_CLK_HZ   = 14318000;
    localparam int PS2_INHIBIT_CYC  = PS2_SYS_CLK_HZ / 1000000 * 120 + (PS2_SYS_CLK_HZ % 1000000) * 120 / 1000000; // 120 us
    localparam int PS2_START_TO_CYC = PS2_SYS_CLK_HZ / 1000 * 15;   // 15 ms
    localparam int PS2_FRAME_TO_CYC = PS2_SYS_CLK_HZ / 1000 * 2;    // 2 ms
    localparam int PS2_FILT_LEN     = 8;

    // Bits shifted out after the start bit: data LSB first, odd parity, stop
    function automatic logic [9:0] ps2_frame(input logic [7:0] d);
        return {1'b1, ~^d, d};
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// PS/2 clock conditioning: 2-FF synchronizer, run-length debounce and a
// single-cycle strobe on every accepted high-to-low transition.
module ps2_line_filter #(
    parameter int FILT_LEN = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin_i,
    output logic level_o,
    output logic fall_o
);

    localparam int CW = $clog2(FILT_LEN + 1);

    logic [1:0]    sync_q;
    logic          level_q;
    logic          fall_q;
    logic [CW-1:0] cnt_q;

    // Synchronize, then accept a new level only after FILT_LEN equal samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= 2'b11;   // idle bus floats high
            level_q <= 1'b1;
            fall_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q <= {sync_q[0], pin_i};
            fall_q <= 1'b0;
            if (sync_q[1] == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CW'(FILT_LEN - 1)) begin
                level_q <= sync_q[1];
                fall_q  <= level_q;  // old level 1 means this is a falling edge
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign level_o = level_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues the start bit,
// shifts the byte out on device clock falls and checks the device ACK.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYC  = PS2_INHIBIT_CYC,
    parameter int START_TO_CYC = PS2_START_TO_CYC,
    parameter int FRAME_TO_CYC = PS2_FRAME_TO_CYC,
    parameter int FILT_LEN     = PS2_FILT_LEN
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic       rx_inhibit,
    output logic       done,
    output logic       ack_ok,
    output logic       err_noack,
    output logic       err_timeout
);

    localparam int TMAX0 = (INHIBIT_CYC > START_TO_CYC) ? INHIBIT_CYC : START_TO_CYC;
    localparam int TMAX  = (TMAX0 > FRAME_TO_CYC) ? TMAX0 : FRAME_TO_CYC;
    localparam int TW    = $clog2(TMAX + 1);

    ps2_state_e  state_q;
    logic [9:0]  frame_q;
    logic [3:0]  idx_q;
    logic [TW-1:0] timer_q;
    logic        clk_oe_q, dat_oe_q;
    logic        done_q, ack_ok_q, noack_q, tout_q;
    logic [1:0]  dsync_q;
    logic        clk_lvl, clk_fall, dat_s;
    logic        frame_exp;

    ps2_line_filter #(.FILT_LEN(FILT_LEN)) u_clk_filt (
        .clk     (clk),
        .rst_n   (rst_n),
        .pin_i   (ps2_clk_in),
        .level_o (clk_lvl),
        .fall_o  (clk_fall)
    );

    // Data pin only needs synchronizing; it is sampled on filtered clock events
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) dsync_q <= 2'b11;
        else        dsync_q <= {dsync_q[0], ps2_dat_in};
    end

    assign dat_s     = dsync_q[1];
    assign frame_exp = (timer_q == TW'(FRAME_TO_CYC - 1));

    // Transaction FSM; line enables and status are registered here. Error
    // exits release the bus and report in the same edge that returns to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            frame_q  <= '0;
            idx_q    <= '0;
            timer_q  <= '0;
            clk_oe_q <= 1'b0;
            dat_oe_q <= 1'b0;
            done_q   <= 1'b0;
            ack_ok_q <= 1'b0;
            noack_q  <= 1'b0;
            tout_q   <= 1'b0;
        end else begin
            done_q   <= 1'b0;
            ack_ok_q <= 1'b0;
            noack_q  <= 1'b0;
            tout_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (tx_valid && tx_ready) begin
                        frame_q  <= ps2_frame(tx_data);
                        timer_q  <= '0;
                        clk_oe_q <= 1'b1;
                        dat_oe_q <= 1'b0;
                        state_q  <= ST_INHIBIT;
                    end
                end
                ST_INHIBIT: begin
                    if (timer_q == TW'(INHIBIT_CYC - 1)) begin
                        clk_oe_q <= 1'b0;
                        dat_oe_q <= 1'b1;   // start bit
                        timer_q  <= '0;
                        state_q  <= ST_START;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                ST_START: begin
                    if (clk_fall) begin
                        dat_oe_q <= ~frame_q[0];
                        idx_q    <= 4'd1;
                        timer_q  <= '0;
                        state_q  <= ST_BITS;
                    end else if (timer_q == TW'(START_TO_CYC - 1)) begin
                        clk_oe_q <= 1'b0;
                        dat_oe_q <= 1'b0;
                        done_q   <= 1'b1;
                        tout_q   <= 1'b1;
                        state_q  <= ST_IDLE;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                ST_BITS: begin
                    timer_q <= timer_q + 1'b1;
                    if (clk_fall) begin
                        dat_oe_q <= ~frame_q[idx_q];  // stop bit is 1, so the line is released
                        idx_q    <= idx_q + 1'b1;
                        if (idx_q == 4'd9) state_q <= ST_ACK;
                    end else if (frame_exp) begin
                        dat_oe_q <= 1'b0;
                        done_q   <= 1'b1;
                        tout_q   <= 1'b1;
                        state_q  <= ST_IDLE;
                    end
                end
                ST_ACK: begin
                    timer_q <= timer_q + 1'b1;
                    if (clk_fall) begin
                        if (!dat_s) begin
                            state_q <= ST_ACK_REL;
                        end else begin
                            dat_oe_q <= 1'b0;
                            done_q   <= 1'b1;
                            noack_q  <= 1'b1;
                            state_q  <= ST_IDLE;
                        end
                    end else if (frame_exp) begin
                        dat_oe_q <= 1'b0;
                        done_q   <= 1'b1;
                        tout_q   <= 1'b1;
                        state_q  <= ST_IDLE;
                    end
                end
                ST_ACK_REL: begin
                    timer_q <= timer_q + 1'b1;
                    if (clk_lvl && dat_s) begin
                        done_q   <= 1'b1;
                        ack_ok_q <= 1'b1;
                        state_q  <= ST_IDLE;
                    end else if (frame_exp) begin
                        dat_oe_q <= 1'b0;
                        done_q   <= 1'b1;
                        tout_q   <= 1'b1;
                        state_q  <= ST_IDLE;
                    end
                end
                default: begin
                    clk_oe_q <= 1'b0;
                    dat_oe_q <= 1'b0;
                    state_q  <= ST_IDLE;
                end
            endcase
        end
    end

    // Ready stays low through the done cycle so a new request lands after it
    assign tx_ready    = (state_q == ST_IDLE) && !done_q;
    assign rx_inhibit  = (state_q != ST_IDLE);
    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_dat_oe  = dat_oe_q;
    assign done        = done_q;
    assign ack_ok      = ack_ok_q;
    assign err_noack   = noack_q;
    assign err_timeout = tout_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a wired-AND PS/2 device model.
module tb_ps2_host_tx;

    localparam int INH = 1718;
    localparam int STO = 4000;    // shortened start timeout keeps the run small
    localparam int FTO = 28636;
    localparam int FL  = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, ps2_clk_in, ps2_dat_in, ps2_clk_oe, ps2_dat_oe;
    logic       rx_inhibit, done, ack_ok, err_noack, err_timeout;
    logic       dev_clk_low = 1'b0, dev_dat_low = 1'b0;

    ps2_host_tx #(
        .INHIBIT_CYC (INH),
        .START_TO_CYC(STO),
        .FRAME_TO_CYC(FTO),
        .FILT_LEN    (FL)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .ps2_clk_in (ps2_clk_in),
        .ps2_dat_in (ps2_dat_in),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_dat_oe (ps2_dat_oe),
        .rx_inhibit (rx_inhibit),
        .done       (done),
        .ack_ok     (ack_ok),
        .err_noack  (err_noack),
        .err_timeout(err_timeout)
    );

    // Open-drain bus: either side pulling low wins
    assign ps2_clk_in = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_dat_in = ~(ps2_dat_oe | dev_dat_low);

    always #5 clk = ~clk;

    int vecs = 0;
    int errs = 0;

    // Capture status on every done pulse and ready on the following cycle
    int   done_cnt = 0;
    logic done_prev = 1'b0;
    logic d_ack, d_noack, d_to, d_coe, d_doe, d_rdy, d_rdy_after;
    always @(negedge clk) begin
        done_prev <= done;
        if (done_prev) d_rdy_after <= tx_ready;
        if (done) begin
            done_cnt <= done_cnt + 1;
            d_ack    <= ack_ok;
            d_noack  <= err_noack;
            d_to     <= err_timeout;
            d_coe    <= ps2_clk_oe;
            d_doe    <= ps2_dat_oe;
            d_rdy    <= tx_ready;
        end
    end

    typedef struct {
        logic [7:0] data;
        int         half;     // device half period in cycles, 0 = device silent
        bit         do_ack;
        bit         glitch;
        logic [9:0] exp_bits; // {stop, parity, data} as seen on the line
        bit         exp_ack;
        bit         exp_noack;
        bit         exp_to;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Device clocks out 11 falls, samples the host line in each low phase
    task automatic dev_frame(input int h, input bit do_ack, input bit glitch, output logic [9:0] bits);
        bits = '0;
        wait_cyc(h);
        for (int k = 1; k <= 11; k++) begin
            if (k == 11 && do_ack) dev_dat_low = 1'b1;
            dev_clk_low = 1'b1;
            wait_cyc(h);
            if (k <= 10) bits[k-1] = ps2_dat_in;
            dev_clk_low = 1'b0;
            if (glitch && k == 5) begin
                wait_cyc(h / 2);
                dev_clk_low = 1'b1;
                wait_cyc(3);
                dev_clk_low = 1'b0;
                wait_cyc(h - h / 2 - 3);
            end else begin
                wait_cyc(h);
            end
        end
        dev_dat_low = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int n;
        int c0;
        logic [9:0] bits;
        c0 = done_cnt;
        chk("ready_idle", tx_ready, 1);
        tx_data  = v.data;
        tx_valid = 1'b1;
        wait_cyc(1);
        tx_valid = 1'b0;
        chk("accept_clk_oe", ps2_clk_oe, 1);
        chk("busy_ready", tx_ready, 0);
        chk("busy_inhibit", rx_inhibit, 1);
        n = 1;
        while (ps2_clk_oe === 1'b1 && n < INH + 50) begin
            wait_cyc(1);
            if (ps2_clk_oe) n++;
        end
        chk("inhibit_cycles", n, INH);
        chk("start_bit_oe", ps2_dat_oe, 1);
        if (v.half == 0) begin
            n = 0;
            while (!done && n < STO + 50) begin
                wait_cyc(1);
                n++;
            end
            chk("start_timeout_cycles", n, STO);
        end else begin
            dev_frame(v.half, v.do_ack, v.glitch, bits);
            chk("line_bits", bits, v.exp_bits);
        end
        n = 0;
        while (done_cnt == c0 && n < FTO) begin
            wait_cyc(1);
            n++;
        end
        chk("done_seen", done_cnt, c0 + 1);
        chk("ack_ok", d_ack, v.exp_ack);
        chk("err_noack", d_noack, v.exp_noack);
        chk("err_timeout", d_to, v.exp_to);
        chk("done_clk_oe", d_coe, 0);
        chk("done_dat_oe", d_doe, 0);
        chk("done_ready", d_rdy, 0);
        wait_cyc(2);
        chk("ready_after_done", d_rdy_after, 1);
        chk("done_single", done_cnt, c0 + 1);
        chk("idle_clk_oe", ps2_clk_oe, 0);
        chk("idle_dat_oe", ps2_dat_oe, 0);
        chk("idle_inhibit", rx_inhibit, 0);
    endtask

    vec_t vt[5];
    vec_t v_ff;

    initial begin
        int n;
        int c0;
        vt[0] = '{8'hED, 573, 1'b1, 1'b0, 10'h3ED, 1'b1, 1'b0, 1'b0}; // 12.5 kHz device
        vt[1] = '{8'hF4,  40, 1'b1, 1'b0, 10'h2F4, 1'b1, 1'b0, 1'b0}; // parity 0
        vt[2] = '{8'h5A,  40, 1'b0, 1'b0, 10'h35A, 1'b0, 1'b1, 1'b0}; // no ACK
        vt[3] = '{8'hED,  40, 1'b1, 1'b1, 10'h3ED, 1'b1, 1'b0, 1'b0}; // clock glitch
        vt[4] = '{8'hF4,   0, 1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 1'b1}; // silent device
        v_ff  = '{8'hFF,  40, 1'b1, 1'b0, 10'h3FF, 1'b1, 1'b0, 1'b0};

        wait_cyc(3);
        chk("rst_ready", tx_ready, 1);
        chk("rst_clk_oe", ps2_clk_oe, 0);
        chk("rst_dat_oe", ps2_dat_oe, 0);
        chk("rst_inhibit", rx_inhibit, 0);
        chk("rst_status", {done, ack_ok, err_noack, err_timeout}, 0);
        rst_n = 1'b1;
        wait_cyc(2);

        for (int i = 0; i < 5; i++) run_vec(vt[i]);

        // Reset mid-frame after the fifth device fall
        c0 = done_cnt;
        tx_data  = 8'h00;
        tx_valid = 1'b1;
        wait_cyc(1);
        tx_valid = 1'b0;
        n = 0;
        while (ps2_clk_oe === 1'b1 && n < INH + 50) begin
            wait_cyc(1);
            n++;
        end
        wait_cyc(40);
        for (int k = 1; k <= 5; k++) begin
            dev_clk_low = 1'b1;
            wait_cyc(40);
            if (k < 5) begin
                dev_clk_low = 1'b0;
                wait_cyc(40);
            end
        end
        chk("pre_reset_dat_oe", ps2_dat_oe, 1);
        chk("pre_reset_inhibit", rx_inhibit, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_dat_oe", ps2_dat_oe, 0);
        chk("async_rst_clk_oe", ps2_clk_oe, 0);
        chk("async_rst_ready", tx_ready, 1);
        dev_clk_low = 1'b0;
        wait_cyc(3);
        rst_n = 1'b1;
        wait_cyc(2);
        chk("post_rst_ready", tx_ready, 1);
        chk("post_rst_inhibit", rx_inhibit, 0);
        chk("post_rst_no_done", done_cnt, c0);
        run_vec(v_ff);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
